bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the accumulator core's 8-bit-address / 32-bit-data memory bus. It lets the core's load/store port (master 0) and a host/loader port (master 1) share a single slave memory. Each transfer uses a valid/ready handshake on the master side and a req/ack handshake on the slave side. Arbitration is round-robin, and an optional watchdog aborts slave transfers that never complete.

---
 rtl/bus_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Two-master / one-slave round-robin arbiter for the accumulator
//             core memory bus. Master side: valid/ready. Slave side: req/ack.
//             All outputs are registered.
//  Options  : BUS_ARB_TIMEOUT_EN - builds a WAIT watchdog that aborts a slave
//             transfer after TIMEOUT cycles and reports err to the master.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          m0_valid,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_valid,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ack,
  input  logic [DW-1:0] s_rdata,
  output logic          grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          pri_q, pri_d;
  logic          grant_q, grant_d;
  logic          s_req_q, s_req_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  // Combinational helpers: winning master in IDLE, completion of the slave leg
  logic          sel;
  logic          fire;
  logic [DW-1:0] fire_rdata;

`ifdef BUS_ARB_TIMEOUT_EN
  // Last counter value before abort; an ack on that same edge still wins
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       fire_err;
  logic       m0_err_q, m0_err_d;
  logic       m1_err_q, m1_err_d;
`endif

  // Next-state, arbitration and response formation
  always_comb begin
    state_d    = state_q;
    pri_d      = pri_q;
    grant_d    = grant_q;
    s_req_d    = s_req_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = '0;
    m1_rdata_d = '0;
    sel        = 1'b0;
    fire       = 1'b0;
    fire_rdata = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    fire_err   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          // Both requesting: the round-robin pointer decides
          sel       = (m0_valid && m1_valid) ? pri_q : m1_valid;
          grant_d   = sel;
          s_req_d   = 1'b1;
          s_we_d    = sel ? m1_we    : m0_we;
          s_addr_d  = sel ? m1_addr  : m0_addr;
          s_wdata_d = sel ? m1_wdata : m0_wdata;
          state_d   = ST_WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (s_ack) begin
          fire       = 1'b1;
          fire_rdata = s_we_q ? '0 : s_rdata;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          fire     = 1'b1;
          fire_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        pri_d   = ~grant_q;
        grant_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Slave leg finished (ack or abort): release the slave, answer the owner
    if (fire) begin
      s_req_d = 1'b0;
      state_d = ST_RESP;
      if (grant_q) begin
        m1_ready_d = 1'b1;
        m1_rdata_d = fire_rdata;
      end else begin
        m0_ready_d = 1'b1;
        m0_rdata_d = fire_rdata;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      m0_err_d = ~grant_q & fire_err;
      m1_err_d =  grant_q & fire_err;
`endif
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      pri_q      <= 1'b0;
      grant_q    <= 1'b0;
      s_req_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pri_q      <= pri_d;
      grant_q    <= grant_d;
      s_req_q    <= s_req_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

`ifdef BUS_ARB_TIMEOUT_EN
  assign m0_err = m0_err_q;
  assign m1_err = m1_err_q;
`else
  // Without the watchdog a transfer can never abort
  logic [7:0] unused_timeout;
  assign unused_timeout = TIMEOUT[7:0];
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed scoreboard bench for bus_arbiter. Stimulus queues the
//             expected master response; a monitor pops it on every ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        CLK, RSTN;
  logic        m0_valid, m0_we, m0_ready, m0_err;
  logic [7:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_valid, m1_we, m1_ready, m1_err;
  logic [7:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        s_req, s_we, s_ack, grant;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata, s_rdata;

  typedef struct { bit port; logic [31:0] rdata; bit err; } exp_t;
  typedef struct { bit port; int cyc; } rdy_t;

  exp_t exp_q[$];
  rdy_t rdy_log[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ack_delay = 1;
  bit          ack_never = 0;
  bit          ack_by_addr = 0;
  logic [31:0] ack_data = '0;

  bus_arbiter dut (
    .CLK(CLK), .RSTN(RSTN),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input bit p, input logic [31:0] d, input bit e);
    exp_t x;
    x.port = p; x.rdata = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_sreq(input string name, input int max);
    int n = 0;
    while (s_req !== 1'b1 && n < max) begin @(negedge CLK); n++; end
    chk(name, {63'd0, s_req}, 64'd1);
  endtask

  task automatic wait_rdy(input string name, input bit port, input int max);
    int n = 0;
    while ((port ? m1_ready : m0_ready) !== 1'b1 && n < max) begin @(negedge CLK); n++; end
    chk(name, {63'd0, (port ? m1_ready : m0_ready)}, 64'd1);
  endtask

  // Counts cycles with s_req high, checking the frozen payload each cycle
  task automatic hold_req(input string name, input bit we, input logic [7:0] addr,
                          input logic [31:0] wd, input bit g, output int n);
    n = 0;
    while (s_req === 1'b1 && n < 400) begin
      chk({name, "_payload"}, {22'd0, s_we, s_addr, s_wdata, grant}, {22'd0, we, addr, wd, g});
      @(negedge CLK);
      n++;
    end
  endtask

  // Slave model: ack at the ack_delay-th WAIT edge
  initial begin
    int wcnt;
    wcnt    = 0;
    s_ack   = 1'b0;
    s_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge CLK);
      if (s_req === 1'b1 && !ack_never) begin
        wcnt++;
        if (wcnt == ack_delay) begin
          s_ack   = 1'b1;
          s_rdata = ack_by_addr ? (32'hA500_0000 | {24'd0, s_addr}) : ack_data;
        end else begin
          s_ack   = 1'b0;
          s_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        wcnt    = 0;
        s_ack   = 1'b0;
        s_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ready pulse
  initial begin
    bit   prev_rdy;
    bit   p;
    exp_t e;
    rdy_t r;
    prev_rdy = 1'b0;
    forever begin
      @(negedge CLK);
      if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
        chk("ready_one_cycle", {63'd0, prev_rdy}, 64'd0);
        if (m0_ready === 1'b1 && m1_ready === 1'b1) begin
          chk("both_ready", 64'd1, 64'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_ready", {63'd0, m1_ready}, 64'd2);
        end else begin
          e = exp_q.pop_front();
          p = m1_ready;
          chk("sb_port", {63'd0, p}, {63'd0, e.port});
          chk("sb_rdata", {32'd0, (p ? m1_rdata : m0_rdata)}, {32'd0, e.rdata});
          chk("sb_err", {63'd0, (p ? m1_err : m0_err)}, {63'd0, e.err});
          chk("sb_other_quiet", {31'd0, (p ? {m0_rdata, m0_err} : {m1_rdata, m1_err})}, 64'd0);
          r.port = p; r.cyc = cyc;
          rdy_log.push_back(r);
        end
        prev_rdy = 1'b1;
      end else begin
        chk("idle_outputs", {62'd0, (|m0_rdata) | m0_err, (|m1_rdata) | m1_err}, 64'd0);
        prev_rdy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench did not complete in time");
  end

  initial begin
    int c0, n, pulses, base;
    RSTN = 1'b0;
    m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(negedge CLK);

    // Reset state
    chk("rst_sreq", {63'd0, s_req}, 64'd0);
    chk("rst_grant", {63'd0, grant}, 64'd0);
    chk("rst_spayload", {23'd0, s_we, s_addr, s_wdata}, 64'd0);
    chk("rst_m0", {30'd0, m0_ready, m0_err, m0_rdata}, 64'd0);
    chk("rst_m1", {30'd0, m1_ready, m1_err, m1_rdata}, 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    // Single read, 1 WAIT cycle
    ack_by_addr = 0; ack_data = 32'h0000_00FF; ack_delay = 1;
    expect_rsp(1'b0, 32'h0000_00FF, 1'b0);
    m0_we = 0; m0_addr = 8'h08; m0_wdata = '0; m0_valid = 1;
    c0 = cyc;
    wait_sreq("rd_sreq", 10);
    chk("rd_s_addr", {56'd0, s_addr}, 64'h08);
    chk("rd_s_we", {63'd0, s_we}, 64'd0);
    chk("rd_grant", {63'd0, grant}, 64'd0);
    wait_rdy("rd_ready", 1'b0, 10);
    chk("rd_latency", 64'(cyc - c0), 64'd2);
    chk("rd_m1_ready", {63'd0, m1_ready}, 64'd0);
    m0_valid = 0;
    @(negedge CLK);
    chk("rd_pulse_end", {63'd0, m0_ready}, 64'd0);

    // Contention from reset: m0, m1, m0, m1, 3 cycles apart
    RSTN = 1'b0;
    ack_by_addr = 1; ack_delay = 1;
    m0_valid = 1; m0_we = 0; m0_addr = 8'h10;
    m1_valid = 1; m1_we = 0; m1_addr = 8'h20; m1_wdata = '0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++)
      expect_rsp(i[0], (i[0] ? 32'hA500_0020 : 32'hA500_0010), 1'b0);
    base = rdy_log.size();
    RSTN = 1'b1;
    n = 0; pulses = 0;
    while (pulses < 4 && n < 60) begin
      @(negedge CLK); n++;
      if (m0_ready === 1'b1 || m1_ready === 1'b1) pulses++;
    end
    m0_valid = 0; m1_valid = 0;
    chk("cont_pulses", 64'(pulses), 64'd4);
    @(negedge CLK);
    chk("cont_log_len", 64'(rdy_log.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < rdy_log.size()) begin
        chk("cont_order", {63'd0, rdy_log[base+i].port}, {63'd0, i[0]});
        if (i > 0)
          chk("cont_spacing", 64'(rdy_log[base+i].cyc - rdy_log[base+i-1].cyc), 64'd3);
      end
    end

    // Write with a 5-cycle slave delay
    ack_by_addr = 0; ack_data = 32'h1234_5678; ack_delay = 5;
    expect_rsp(1'b1, 32'h0, 1'b0);
    m1_we = 1; m1_addr = 8'h42; m1_wdata = 32'hDEAD_BEEF; m1_valid = 1;
    wait_sreq("wr_sreq", 10);
    hold_req("wr", 1'b1, 8'h42, 32'hDEAD_BEEF, 1'b1, n);
    chk("wr_req_cycles", 64'(n), 64'd5);
    wait_rdy("wr_ready", 1'b1, 5);
    m1_valid = 0; m1_we = 0;
    @(negedge CLK);

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog abort after 15 WAIT cycles
    ack_never = 1;
    expect_rsp(1'b0, 32'h0, 1'b1);
    m0_we = 0; m0_addr = 8'h30; m0_wdata = '0; m0_valid = 1;
    wait_sreq("tmo_sreq", 10);
    hold_req("tmo", 1'b0, 8'h30, 32'h0, 1'b0, n);
    chk("tmo_req_cycles", 64'(n), 64'd15);
    wait_rdy("tmo_ready", 1'b0, 5);
    m0_valid = 0;
    @(negedge CLK);
    // Ack on the 15th WAIT edge wins over the abort
    ack_never = 0; ack_delay = 15; ack_data = 32'h0000_0055;
    expect_rsp(1'b0, 32'h0000_0055, 1'b0);
    m0_addr = 8'h31; m0_valid = 1;
    wait_sreq("tmo2_sreq", 10);
    hold_req("tmo2", 1'b0, 8'h31, 32'h0, 1'b0, n);
    chk("tmo2_req_cycles", 64'(n), 64'd15);
    wait_rdy("tmo2_ready", 1'b0, 5);
    m0_valid = 0;
    @(negedge CLK);
`endif

    // Reset mid-transfer; first move the round-robin pointer to m1
    ack_never = 0; ack_by_addr = 1; ack_delay = 1;
    expect_rsp(1'b0, 32'hA500_0044, 1'b0);
    m0_we = 0; m0_addr = 8'h44; m0_wdata = 32'h1111_1111; m0_valid = 1;
    wait_rdy("pre_rst_ready", 1'b0, 10);
    m0_valid = 0;
    @(negedge CLK);
    ack_never = 1;
    m0_addr = 8'h48; m0_valid = 1;
    wait_sreq("rst_mid_sreq", 10);
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("rst_async_sreq", {63'd0, s_req}, 64'd0);
    chk("rst_async_grant", {63'd0, grant}, 64'd0);
    chk("rst_async_spayload", {23'd0, s_we, s_addr, s_wdata}, 64'd0);
    chk("rst_async_m", {60'd0, m0_ready, m0_err, m1_ready, m1_err}, 64'd0);
    chk("rst_async_rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(negedge CLK);
    ack_never = 0;
    m0_addr = 8'h50; m0_wdata = '0; m0_valid = 1;
    m1_we = 0; m1_addr = 8'h60; m1_wdata = '0; m1_valid = 1;
    expect_rsp(1'b0, 32'hA500_0050, 1'b0);
    expect_rsp(1'b1, 32'hA500_0060, 1'b0);
    @(negedge CLK);
    RSTN = 1'b1;
    wait_sreq("post_rst_sreq", 10);
    chk("post_rst_grant", {63'd0, grant}, 64'd0);
    chk("post_rst_addr", {56'd0, s_addr}, 64'h50);
    wait_rdy("post_rst_m0_ready", 1'b0, 10);
    m0_valid = 0;
    wait_sreq("post_rst_sreq2", 10);
    chk("post_rst_grant2", {63'd0, grant}, 64'd1);
    wait_rdy("post_rst_m1_ready", 1'b1, 10);
    m1_valid = 0;
    @(negedge CLK);

    // Abandoned request: m1 drops valid after grant, m0 waits behind it
    ack_delay = 2;
    expect_rsp(1'b1, 32'hA500_0070, 1'b0);
    expect_rsp(1'b0, 32'hA500_0080, 1'b0);
    m1_we = 0; m1_addr = 8'h70; m1_valid = 1;
    wait_sreq("ab_sreq1", 10);
    chk("ab_grant1", {63'd0, grant}, 64'd1);
    m1_valid = 0;
    m0_we = 0; m0_addr = 8'h80; m0_valid = 1;
    wait_rdy("ab_m1_ready", 1'b1, 10);
    wait_sreq("ab_sreq2", 10);
    chk("ab_grant2", {63'd0, grant}, 64'd0);
    chk("ab_addr2", {56'd0, s_addr}, 64'h80);
    wait_rdy("ab_m0_ready", 1'b0, 10);
    m0_valid = 0;

    repeat (3) @(negedge CLK);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
